pll_lock_supervisor: RTL and testbench
======================================

Name: pll_lock_supervisor

Overview:
- Sits on the far side of the core PLL's rst/locked interface. It drives the PLL reset input and consumes the PLL locked output.
- Runs on the free-running 74.25 MHz reference clock, so it operates whether or not the PLL is locked.
- Sequences the PLL reset, waits for stable lock, then releases the core reset. On loss of lock it re-resets the PLL with bounded retries.
- Its output core_reset_n gates all logic clocked from the PLL outputs (18 MHz, 6 MHz, 6 MHz phase-shifted).

Parameters:
- SYNC_STAGES, 2: synchroniser depth for pll_locked (min 2).
- RST_PULSE, 32: pll_rst high time in clocks.
- STABLE_CYCLES, 1024: consecutive synced-locked clocks required before core release.
- LOSS_CYCLES, 16: consecutive synced-unlocked clocks in RUN that count as loss (glitch filter).
- TIMEOUT_CYCLES, 1048576: max clocks in WAIT_LOCK before a retry.
- RETRY_MAX, 7: retries allowed before FAILED. Width of retry_count is 3 bits; RETRY_MAX must be 7 or less.

Ports:
- clk_74a  in  1  reference clock, same net as the PLL refclk.
- reset_n  in  1  asynchronous active-low reset.
- pll_locked  in  1  PLL locked, asynchronous to clk_74a.
- force_relock  in  1  single-cycle request to re-reset the PLL.
- pll_rst  out  1  PLL reset, active high.
- core_reset_n  out  1  core reset, active low.
- pll_ok  out  1  high only in RUN.
- fail  out  1  high only in FAILED.
- retry_count  out  3  retries consumed in the current acquisition.
- lock_loss_count  out  8  see Optional Feature.

Behaviour:
- One clock. reset_n asynchronously forces the following; all outputs are registered.
  - state=RESET_PLL, all counters 0, synchroniser 0.
  - pll_rst=1, core_reset_n=0, pll_ok=0, fail=0, retry_count=0, lock_loss_count=0.
- locked_s = pll_locked through SYNC_STAGES flops. Latency from input edge to FSM visibility is SYNC_STAGES clocks.
- A single shared cycle counter cnt is sized for the largest of RST_PULSE, STABLE_CYCLES, LOSS_CYCLES and TIMEOUT_CYCLES. It clears on every state change.
- RESET_PLL:
  - pll_rst=1, core_reset_n=0.
  - When cnt==RST_PULSE-1, go to WAIT_LOCK.
  - force_relock is ignored here.
- WAIT_LOCK:
  - pll_rst=0.
  - If locked_s=1, go to STABILIZE.
  - Else if cnt==TIMEOUT_CYCLES-1: if retry_count==RETRY_MAX go to FAILED; otherwise retry_count+1 and go to RESET_PLL.
  - force_relock goes to RESET_PLL without incrementing retry_count. It has priority over timeout.
- STABILIZE:
  - locked_s=0 goes to WAIT_LOCK; the timeout restarts.
  - When cnt==STABLE_CYCLES-1 with locked_s=1, go to RUN.
  - force_relock goes to RESET_PLL.
- RUN:
  - core_reset_n=1 and pll_ok=1, asserted on the same edge that enters RUN. retry_count clears on entry.
  - cnt counts consecutive locked_s=0 clocks and clears whenever locked_s=1.
  - When cnt==LOSS_CYCLES-1 with locked_s=0, go to RESET_PLL. core_reset_n=0 and pll_ok=0 on that edge.
  - force_relock goes to RESET_PLL on the next edge. If both occur in the same cycle, force_relock wins; this matters for stats.
- FAILED:
  - pll_rst=0, core_reset_n=0, fail=1.
  - Left only by reset_n, or by force_relock, which goes to RESET_PLL, clears retry_count and sets fail=0.
- Boundary conditions:
  - core_reset_n never deasserts unless locked_s has been held for STABLE_CYCLES.
  - A lock glitch shorter than LOSS_CYCLES in RUN has no visible effect.
  - reset_n asserted mid-operation returns to the reset values immediately (asynchronous). After release, RESET_PLL starts from cnt=0.

Optional Feature:
- Macro: PLL_LOCK_STATS_EN.
- Defined: lock_loss_count is an 8-bit counter that saturates at 255. It increments on each RUN to RESET_PLL transition caused by lock loss; force-caused exits do not count. It clears only on reset_n.
- Undefined: lock_loss_count is tied to 0 and no counter logic is built.

Test Plan:
Use SYNC_STAGES=2, RST_PULSE=4, STABLE_CYCLES=8, LOSS_CYCLES=4, TIMEOUT_CYCLES=64, RETRY_MAX=2.
- Release reset_n; pll_locked rises at clock 10 and stays high -> pll_rst high for clocks 0-3; core_reset_n=1 and pll_ok=1 at clock 10+2+1+8; retry_count=0.
- pll_locked never rises -> pll_rst pulses 3 times in total; retry_count goes 1, then 2; fail=1 after 3×(4+64) clocks; core_reset_n stays 0.
- In RUN, pll_locked low for 3 clocks -> no change. Low for 4 clocks -> core_reset_n=0 and pll_rst=1, 2+4 clocks after the input fall; lock_loss_count=1 with PLL_LOCK_STATS_EN.
- In STABILIZE, pll_locked drops at cnt=5 -> returns to WAIT_LOCK; core_reset_n stays 0; re-lock needs a full 8 clocks.
- force_relock pulse in RUN -> pll_rst=1 next edge, core_reset_n=0; lock_loss_count unchanged. force_relock in FAILED -> fail=0, retry_count=0, new pll_rst pulse of 4 clocks.
- reset_n asserted during STABILIZE -> outputs return to reset values asynchronously, with no clock edge needed.

Source files
------------

// File: rtl/pll_lock_supervisor.sv
// PLL reset sequencer and lock supervisor on the free-running 74.25 MHz reference clock.
// Define PLL_LOCK_STATS_EN to build the saturating lock-loss counter behind lock_loss_count.
module pll_lock_supervisor #(
    parameter int SYNC_STAGES    = 2,
    parameter int RST_PULSE      = 32,
    parameter int STABLE_CYCLES  = 1024,
    parameter int LOSS_CYCLES    = 16,
    parameter int TIMEOUT_CYCLES = 1048576,
    parameter int RETRY_MAX      = 7
) (
    input  logic       clk_74a,
    input  logic       reset_n,
    input  logic       pll_locked,
    input  logic       force_relock,
    output logic       pll_rst,
    output logic       core_reset_n,
    output logic       pll_ok,
    output logic       fail,
    output logic [2:0] retry_count,
    output logic [7:0] lock_loss_count
);

    localparam int MAX_A   = (RST_PULSE > STABLE_CYCLES) ? RST_PULSE : STABLE_CYCLES;
    localparam int MAX_B   = (LOSS_CYCLES > TIMEOUT_CYCLES) ? LOSS_CYCLES : TIMEOUT_CYCLES;
    localparam int MAX_CNT = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOSS_LAST    = CNT_W'(LOSS_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]       RETRY_LAST   = 3'(RETRY_MAX);

    typedef enum logic [2:0] {
        RESET_PLL,
        WAIT_LOCK,
        STABILIZE,
        RUN,
        FAILED
    } state_t;

    state_t             state, state_next;
    logic [SYNC_STAGES-1:0] sync;
    logic               locked_s;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic [2:0]         retry_next;

    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], pll_locked};
        end
    end

    assign locked_s = sync[SYNC_STAGES-1];

    // force_relock takes priority in every state that honours it; the shared counter restarts on any state change
    always_comb begin
        state_next = state;
        cnt_next   = cnt + 1'b1;
        retry_next = retry_count;
        case (state)
            RESET_PLL: begin
                if (cnt == RST_LAST) state_next = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (force_relock) begin
                    state_next = RESET_PLL;
                end else if (locked_s) begin
                    state_next = STABILIZE;
                end else if (cnt == TIMEOUT_LAST) begin
                    if (retry_count == RETRY_LAST) begin
                        state_next = FAILED;
                    end else begin
                        retry_next = retry_count + 3'd1;
                        state_next = RESET_PLL;
                    end
                end
            end
            STABILIZE: begin
                if (force_relock) begin
                    state_next = RESET_PLL;
                end else if (!locked_s) begin
                    state_next = WAIT_LOCK;
                end else if (cnt == STABLE_LAST) begin
                    state_next = RUN;
                    retry_next = '0;
                end
            end
            RUN: begin
                if (force_relock) begin
                    state_next = RESET_PLL;
                end else if (locked_s) begin
                    cnt_next = '0;
                end else if (cnt == LOSS_LAST) begin
                    state_next = RESET_PLL;
                end
            end
            FAILED: begin
                cnt_next = '0;
                if (force_relock) begin
                    state_next = RESET_PLL;
                    retry_next = '0;
                end
            end
            default: state_next = RESET_PLL;
        endcase
        if (state_next != state) cnt_next = '0;
    end

    // Outputs are decoded from the next state so they change on the same edge as the state
    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            state        <= RESET_PLL;
            cnt          <= '0;
            retry_count  <= '0;
            pll_rst      <= 1'b1;
            core_reset_n <= 1'b0;
            pll_ok       <= 1'b0;
            fail         <= 1'b0;
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            retry_count  <= retry_next;
            pll_rst      <= (state_next == RESET_PLL);
            core_reset_n <= (state_next == RUN);
            pll_ok       <= (state_next == RUN);
            fail         <= (state_next == FAILED);
        end
    end

`ifdef PLL_LOCK_STATS_EN
    logic loss_exit;

    assign loss_exit = (state == RUN) && !force_relock && !locked_s && (cnt == LOSS_LAST);

    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            lock_loss_count <= '0;
        end else if (loss_exit && (lock_loss_count != 8'hFF)) begin
            lock_loss_count <= lock_loss_count + 8'd1;
        end
    end
`else
    assign lock_loss_count = '0;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Randomised bench for pll_lock_supervisor against a time-since-entry reference model.
// Expects lock_loss_count to count lock losses only when PLL_LOCK_STATS_EN is defined.
module tb_pll_lock_supervisor;

    localparam int SYNC_STAGES    = 2;
    localparam int RST_PULSE      = 4;
    localparam int STABLE_CYCLES  = 8;
    localparam int LOSS_CYCLES    = 4;
    localparam int TIMEOUT_CYCLES = 64;
    localparam int RETRY_MAX      = 2;

    localparam int P_RESET = 0;
    localparam int P_WAIT  = 1;
    localparam int P_STAB  = 2;
    localparam int P_RUN   = 3;
    localparam int P_FAIL  = 4;

    logic       clk_74a      = 1'b0;
    logic       reset_n      = 1'b0;
    logic       pll_locked   = 1'b0;
    logic       force_relock = 1'b0;
    logic       pll_rst;
    logic       core_reset_n;
    logic       pll_ok;
    logic       fail;
    logic [2:0] retry_count;
    logic [7:0] lock_loss_count;

    int checks = 0;
    int errors = 0;

    int m_phase;
    int m_entry;
    int edge_n;
    int m_retry;
    int m_losses;
    int low_run;
    bit lock_hist[$];
    bit cur_lock;

    pll_lock_supervisor #(
        .SYNC_STAGES   (SYNC_STAGES),
        .RST_PULSE     (RST_PULSE),
        .STABLE_CYCLES (STABLE_CYCLES),
        .LOSS_CYCLES   (LOSS_CYCLES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .RETRY_MAX     (RETRY_MAX)
    ) dut (
        .clk_74a        (clk_74a),
        .reset_n        (reset_n),
        .pll_locked     (pll_locked),
        .force_relock   (force_relock),
        .pll_rst        (pll_rst),
        .core_reset_n   (core_reset_n),
        .pll_ok         (pll_ok),
        .fail           (fail),
        .retry_count    (retry_count),
        .lock_loss_count(lock_loss_count)
    );

    always #5 clk_74a = ~clk_74a;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at edge %0d: got %0h, want %0h", tag, edge_n, actual, expected);
        end
    endtask

    task automatic model_reset();
        m_phase  = P_RESET;
        m_entry  = -1;
        edge_n   = 0;
        m_retry  = 0;
        m_losses = 0;
        low_run  = 0;
        lock_hist.delete();
        for (int i = 0; i < SYNC_STAGES; i++) lock_hist.push_back(1'b0);
    endtask

    // The FSM sees the lock input from SYNC_STAGES edges ago; "held" counts edges spent in the current phase
    task automatic model_edge(input bit lock_in, input bit force_in);
        bit seen;
        int held;
        int nxt;
        seen = lock_hist.pop_front();
        lock_hist.push_back(lock_in);
        held = edge_n - m_entry;
        nxt  = m_phase;
        case (m_phase)
            P_RESET: if (held == RST_PULSE) nxt = P_WAIT;
            P_WAIT: begin
                if (force_in) nxt = P_RESET;
                else if (seen) nxt = P_STAB;
                else if (held == TIMEOUT_CYCLES) begin
                    if (m_retry == RETRY_MAX) nxt = P_FAIL;
                    else begin
                        m_retry++;
                        nxt = P_RESET;
                    end
                end
            end
            P_STAB: begin
                if (force_in) nxt = P_RESET;
                else if (!seen) nxt = P_WAIT;
                else if (held == STABLE_CYCLES) begin
                    nxt = P_RUN;
                    m_retry = 0;
                end
            end
            P_RUN: begin
                if (force_in) nxt = P_RESET;
                else begin
                    low_run = seen ? 0 : low_run + 1;
                    if (low_run == LOSS_CYCLES) begin
                        nxt = P_RESET;
                        if (m_losses < 255) m_losses++;
                    end
                end
            end
            default: begin
                if (force_in) begin
                    nxt = P_RESET;
                    m_retry = 0;
                end
            end
        endcase
        if (nxt != m_phase) begin
            m_phase = nxt;
            m_entry = edge_n;
            low_run = 0;
        end
        edge_n++;
    endtask

    task automatic compare_all();
        int exp_losses;
`ifdef PLL_LOCK_STATS_EN
        exp_losses = m_losses;
`else
        exp_losses = 0;
`endif
        checkOutput("pll_rst", 32'(pll_rst), 32'(m_phase == P_RESET));
        checkOutput("core_reset_n", 32'(core_reset_n), 32'(m_phase == P_RUN));
        checkOutput("pll_ok", 32'(pll_ok), 32'(m_phase == P_RUN));
        checkOutput("fail", 32'(fail), 32'(m_phase == P_FAIL));
        checkOutput("retry_count", 32'(retry_count), 32'(m_retry));
        checkOutput("lock_loss_count", 32'(lock_loss_count), 32'(exp_losses));
    endtask

    // Called on a falling edge: drive, step the model on the rising edge, compare on the next falling edge
    task automatic applyStimulus(input bit lock, input bit frc);
        pll_locked   = lock;
        force_relock = frc;
        cur_lock     = lock;
        @(posedge clk_74a);
        model_edge(lock, frc);
        @(negedge clk_74a);
        compare_all();
        force_relock = 1'b0;
    endtask

    task automatic hold_lock(input bit lock, input int cycles);
        for (int i = 0; i < cycles; i++) applyStimulus(lock, 1'b0);
    endtask

    initial begin
        int scenario;
        bit reached;

        model_reset();
        cur_lock = 1'b0;
        repeat (3) @(negedge clk_74a);
        compare_all();
        reset_n = 1'b1;

        hold_lock(1'b0, 10);
        hold_lock(1'b1, 30);
        hold_lock(1'b0, 3);
        hold_lock(1'b1, 6);
        hold_lock(1'b0, 4);
        hold_lock(1'b1, 30);
        applyStimulus(1'b1, 1'b1);
        hold_lock(1'b1, 30);
        hold_lock(1'b0, 4);
        hold_lock(1'b1, 9);
        hold_lock(1'b0, 2);
        hold_lock(1'b1, 20);

        hold_lock(1'b0, 3 * (RST_PULSE + TIMEOUT_CYCLES) + 20);
        checkOutput("reached_failed", 32'(fail), 32'd1);
        applyStimulus(1'b0, 1'b1);
        hold_lock(1'b0, 6);

        for (int s = 0; s < 80; s++) begin
            scenario = $urandom_range(5, 0);
            case (scenario)
                0: hold_lock(1'b1, $urandom_range(40, 10));
                1: hold_lock(1'b0, $urandom_range(6, 1));
                2: applyStimulus(cur_lock, 1'b1);
                3: hold_lock(1'b0, $urandom_range(100, 20));
                4: for (int i = 0; i < 12; i++) applyStimulus(1'($urandom_range(1, 0)), 1'b0);
                default: hold_lock(1'b1, $urandom_range(12, 2));
            endcase
        end

        hold_lock(1'b0, 8);
        reached = 1'b0;
        for (int i = 0; i < 200 && !reached; i++) begin
            applyStimulus(1'b1, 1'b0);
            if (m_phase == P_STAB && (edge_n - m_entry) == 3) reached = 1'b1;
        end
        checkOutput("reach_stabilize", 32'(reached), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge clk_74a);
        compare_all();
        reset_n = 1'b1;
        hold_lock(1'b1, 30);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
